// File: rtl/cv32e40p_alu_sel_ft.sv
// cv32e40p_alu_sel_ft: per-class ALU selection table for fault-tolerant voting.
// The table is rebuilt by a scan FSM whenever a new permanent fault shows up.
module cv32e40p_alu_sel_ft (
   input  logic            clk_gated,
   input  logic            rst_n,
   input  logic [3:0][8:0] permanent_faulty_i,
   input  logic            req_valid_i,
   input  logic [3:0]      req_class_i,
   output logic            req_ready_o,
   output logic            rsp_valid_o,
   output logic [2:0][1:0] rsp_sel_o,
   output logic [1:0]      rsp_mode_o,
   output logic [3:0]      rsp_alu_en_o,
   output logic            rsp_err_o,
   output logic            reconfig_busy_o,
   output logic [7:0]      reconfig_count_o
);

   localparam int N_ALU   = 4;
   localparam int N_CLASS = 9;

   typedef enum logic [1:0] {
      TMR    = 2'b00,
      DMR    = 2'b01,
      SINGLE = 2'b10,
      NONE   = 2'b11
   } mode_e;

   typedef struct packed {
      logic [2:0][1:0] sel;
      mode_e           mode;
      logic [3:0]      alu_en;
   } entry_t;

   typedef enum logic {
      IDLE,
      SCAN
   } state_e;

   localparam entry_t ENTRY_RST = entry_t'({6'b10_01_00, 2'b00, 4'b0111});

   // Three lowest healthy ALUs, degrading to DMR/SINGLE/NONE.
   function automatic entry_t select_entry(input logic [N_ALU-1:0] healthy);
      entry_t     e;
      logic [1:0] h0, h1, h2;
      logic [2:0] n;
      h0 = 2'd0;
      h1 = 2'd0;
      h2 = 2'd0;
      n  = 3'd0;
      for (int a = 0; a < N_ALU; a++) begin
         if (healthy[a]) begin
            if (n == 3'd0)      h0 = 2'(a);
            else if (n == 3'd1) h1 = 2'(a);
            else if (n == 3'd2) h2 = 2'(a);
            n = n + 3'd1;
         end
      end
      e.alu_en = 4'b0000;
      if (n >= 3'd3) begin
         e.sel  = {h2, h1, h0};
         e.mode = TMR;
      end else if (n == 3'd2) begin
         e.sel  = {h0, h1, h0};
         e.mode = DMR;
      end else if (n == 3'd1) begin
         e.sel  = {h0, h0, h0};
         e.mode = SINGLE;
      end else begin
         e.sel  = '0;
         e.mode = NONE;
      end
      if (n != 3'd0) begin
         e.alu_en = (4'b0001 << e.sel[0])
                  | (4'b0001 << e.sel[1])
                  | (4'b0001 << e.sel[2]);
      end
      return e;
   endfunction

   state_e          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [3:0][8:0] snap_q;
   entry_t          table_q [N_CLASS];
   logic [7:0]      count_q;
   logic            new_fault;
   logic            wr_en;
   logic            done;
   logic [N_ALU-1:0] healthy;
   entry_t          scan_entry;
   logic            accept;
   logic            bad_class;

   assign new_fault = |(permanent_faulty_i & ~snap_q);
   assign accept    = req_valid_i && req_ready_o;
   assign bad_class = req_class_i > 4'd8;

   always_comb begin
      healthy = '0;
      for (int a = 0; a < N_ALU; a++) begin
         healthy[a] = ~snap_q[a][idx_q];
      end
      scan_entry = select_entry(healthy);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (new_fault) begin
               state_d = SCAN;
               idx_d   = 4'd0;
            end
         end
         SCAN: begin
            // A fresh fault invalidates the partial pass: start over.
            if (new_fault) begin
               idx_d = 4'd0;
            end else begin
               wr_en = 1'b1;
               if (idx_q == 4'd8) begin
                  state_d = IDLE;
                  idx_d   = 4'd0;
                  done    = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_gated) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= 4'd0;
         snap_q       <= '0;
         count_q      <= 8'd0;
         rsp_valid_o  <= 1'b0;
         rsp_sel_o    <= '0;
         rsp_mode_o   <= 2'b00;
         rsp_alu_en_o <= 4'b0000;
         rsp_err_o    <= 1'b0;
         for (int c = 0; c < N_CLASS; c++) begin
            table_q[c] <= ENTRY_RST;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_q | permanent_faulty_i;
         if (done && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
         end
         if (wr_en) begin
            table_q[idx_q] <= scan_entry;
         end
         rsp_valid_o <= accept;
         if (accept) begin
            if (bad_class) begin
               rsp_sel_o    <= '0;
               rsp_mode_o   <= NONE;
               rsp_alu_en_o <= 4'b0000;
               rsp_err_o    <= 1'b1;
            end else begin
               rsp_sel_o    <= table_q[req_class_i].sel;
               rsp_mode_o   <= table_q[req_class_i].mode;
               rsp_alu_en_o <= table_q[req_class_i].alu_en;
               rsp_err_o    <= 1'b0;
            end
         end
      end
   end

   assign req_ready_o      = (state_q == IDLE);
   assign reconfig_busy_o  = (state_q == SCAN);
   assign reconfig_count_o = count_q;

endmodule

// File: tb/tb_cv32e40p_alu_sel_ft.sv
// tb_cv32e40p_alu_sel_ft: directed plus random checks of the ALU selection table
// against a cycle-level model built from the selection and scan-timing rules.
module tb_cv32e40p_alu_sel_ft;

   logic            clk_gated = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0][8:0] pf = '0;
   logic            req_valid = 1'b0;
   logic [3:0]      req_class = 4'd0;
   logic            req_ready;
   logic            rsp_valid;
   logic [2:0][1:0] rsp_sel;
   logic [1:0]      rsp_mode;
   logic [3:0]      rsp_alu_en;
   logic            rsp_err;
   logic            busy;
   logic [7:0]      count;

   int errors = 0;
   int checks = 0;

   bit m_snap  [4][9];
   bit m_tsnap [4][9];
   int m_busy;
   int m_count;
   logic       e_valid;
   logic [5:0] e_sel;
   logic [1:0] e_mode;
   logic [3:0] e_en;
   logic       e_err;

   cv32e40p_alu_sel_ft dut (
      .clk_gated          (clk_gated),
      .rst_n              (rst_n),
      .permanent_faulty_i (pf),
      .req_valid_i        (req_valid),
      .req_class_i        (req_class),
      .req_ready_o        (req_ready),
      .rsp_valid_o        (rsp_valid),
      .rsp_sel_o          (rsp_sel),
      .rsp_mode_o         (rsp_mode),
      .rsp_alu_en_o       (rsp_alu_en),
      .rsp_err_o          (rsp_err),
      .reconfig_busy_o    (busy),
      .reconfig_count_o   (count)
   );

   always #5 clk_gated = ~clk_gated;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Healthy ALUs of the committed table, lowest index first.
   function automatic void expect_rsp(input int cls, output logic [5:0] sel,
                                      output logic [1:0] mode,
                                      output logic [3:0] en, output logic err);
      int h[$];
      int s0, s1, s2;
      sel  = 6'd0;
      mode = 2'b11;
      en   = 4'd0;
      err  = 1'b0;
      if (cls > 8) begin
         err = 1'b1;
         return;
      end
      for (int a = 0; a < 4; a++) begin
         if (!m_tsnap[a][cls]) h.push_back(a);
      end
      if (h.size() == 0) return;
      if (h.size() >= 3) begin
         s0 = h[0]; s1 = h[1]; s2 = h[2]; mode = 2'b00;
      end else if (h.size() == 2) begin
         s0 = h[0]; s1 = h[1]; s2 = h[0]; mode = 2'b01;
      end else begin
         s0 = h[0]; s1 = h[0]; s2 = h[0]; mode = 2'b10;
      end
      sel = 6'(s0 + 4 * s1 + 16 * s2);
      en  = 4'((1 << s0) | (1 << s1) | (1 << s2));
   endfunction

   task automatic check_all();
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      check("rsp_sel", 32'(rsp_sel), 32'(e_sel));
      check("rsp_mode", 32'(rsp_mode), 32'(e_mode));
      check("rsp_alu_en", 32'(rsp_alu_en), 32'(e_en));
      check("rsp_err", 32'(rsp_err), 32'(e_err));
      check("busy", 32'(busy), 32'(m_busy != 0));
      check("ready", 32'(req_ready), 32'(m_busy == 0));
      check("count", 32'(count), 32'(m_count));
   endtask

   task automatic step();
      bit acc;
      bit nf;
      acc = req_valid && (m_busy == 0);
      if (acc) expect_rsp(int'(req_class), e_sel, e_mode, e_en, e_err);
      e_valid = acc;
      nf = 1'b0;
      for (int a = 0; a < 4; a++) begin
         for (int c = 0; c < 9; c++) begin
            if (pf[a][c] && !m_snap[a][c]) begin
               nf = 1'b1;
               m_snap[a][c] = 1'b1;
            end
         end
      end
      if (nf) begin
         m_busy = 9;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_tsnap = m_snap;
            if (m_count < 255) m_count++;
         end
      end
      @(posedge clk_gated);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic request(input int cls);
      req_valid = 1'b1;
      req_class = 4'(cls);
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      pf        = '0;
      req_valid = 1'b0;
      repeat (2) @(posedge clk_gated);
      #1;
      rst_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         for (int c = 0; c < 9; c++) begin
            m_snap[a][c]  = 1'b0;
            m_tsnap[a][c] = 1'b0;
         end
      end
      m_busy  = 0;
      m_count = 0;
      e_valid = 1'b0;
      e_sel   = 6'd0;
      e_mode  = 2'b00;
      e_en    = 4'd0;
      e_err   = 1'b0;
      check_all();
   endtask

   initial begin
      do_reset();

      // Reset table contents.
      request(5);
      check("rst_sel", 32'(rsp_sel), 32'h24);
      check("rst_en", 32'(rsp_alu_en), 32'h7);
      idle(1);

      // Single fault on ALU 1, class 0.
      pf[1][0] = 1'b1;
      idle(1);
      check("scan_busy", 32'(busy), 32'd1);
      idle(9);
      check("scan_done", 32'(count), 32'd1);
      request(0);
      check("c0_sel", 32'(rsp_sel), 32'h38);
      check("c0_en", 32'(rsp_alu_en), 32'hD);
      request(1);
      check("c1_sel", 32'(rsp_sel), 32'h24);

      // Degradation ladder on class 8.
      pf[0][8] = 1'b1;
      pf[2][8] = 1'b1;
      idle(11);
      request(8);
      check("dmr_sel", 32'(rsp_sel), 32'h1D);
      check("dmr_mode", 32'(rsp_mode), 32'h1);
      check("dmr_en", 32'(rsp_alu_en), 32'hA);
      pf[3][8] = 1'b1;
      idle(11);
      request(8);
      check("single_sel", 32'(rsp_sel), 32'h15);
      check("single_mode", 32'(rsp_mode), 32'h2);
      pf[1][8] = 1'b1;
      idle(11);
      request(8);
      check("none_mode", 32'(rsp_mode), 32'h3);
      check("none_en", 32'(rsp_alu_en), 32'h0);

      // Restart mid-scan, then drop the first fault.
      pf[2][3] = 1'b1;
      idle(4);
      pf[0][5] = 1'b1;
      idle(1);
      pf[2][3] = 1'b0;
      idle(8);
      check("restart_busy", 32'(busy), 32'd1);
      idle(1);
      check("restart_idle", 32'(busy), 32'd0);
      check("restart_cnt", 32'(count), 32'd5);
      request(3);
      check("sticky_sel", 32'(rsp_sel), 32'h34);

      // Request held across a scan.
      pf[0][1] = 1'b1;
      req_valid = 1'b1;
      req_class = 4'd1;
      for (int i = 0; i < 14; i++) step();
      req_valid = 1'b0;
      idle(1);

      // Invalid class.
      request(12);
      check("bad_err", 32'(rsp_err), 32'd1);
      check("bad_mode", 32'(rsp_mode), 32'h3);

      // Reset in scan cycle 5.
      pf[3][7] = 1'b1;
      idle(6);
      do_reset();
      check("rst_ready", 32'(req_ready), 32'd1);
      request(7);
      check("rst_scan_sel", 32'(rsp_sel), 32'h24);
      check("rst_scan_cnt", 32'(count), 32'd0);

      // Random traffic with sporadic faults and one reset.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         req_valid = 1'($urandom_range(0, 1));
         req_class = 4'($urandom_range(0, 11));
         if ($urandom_range(0, 11) == 0)
            pf[$urandom_range(0, 3)][$urandom_range(0, 8)] = 1'b1;
         if ($urandom_range(0, 11) == 0)
            pf[$urandom_range(0, 3)][$urandom_range(0, 8)] = 1'b0;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cv32e40p_alu_sel_ft.md
# cv32e40p_alu_sel_ft

Downstream consumer of the per-ALU/per-class permanent-fault map produced by the ALU error-counter block. It keeps a registered selection table with one entry per operation class, naming which of the 4 ALUs the ID stage dispatches to for voting. The table is rebuilt by a scan FSM whenever a new permanent fault appears. The block answers ID-stage lookup requests through a valid/ready handshake and stalls them while the table is being rebuilt.

## Interface
- N_ALU, 4, number of replicated ALUs; fixed, not overridable.
- N_CLASS, 9, number of operation classes: 0 shift/add, 1 logic, 2 bit-man, 3 bit-count, 4 shuffle, 5 compare, 6 abs/clip, 7 min/max, 8 div/rem.
- clk_gated  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- permanent_faulty_i  in  [3:0][8:0]  fault map indexed [alu][class]; 1 means faulty.
- req_valid_i  in  1  ID stage lookup request.
- req_class_i  in  4  class index of the request.
- req_ready_o  out  1  block can accept a request.
- rsp_valid_o  out  1  response valid; a one-cycle pulse.
- rsp_sel_o  out  [2:0][1:0]  ALU indices for voter slots 0..2.
- rsp_mode_o  out  2  voting mode: 00 TMR, 01 DMR, 10 SINGLE, 11 NONE.
- rsp_alu_en_o  out  4  one-hot union of the selected ALUs; drives ALU and counter clock enables.
- rsp_err_o  out  1  request had an invalid class (req_class_i > 8).
- reconfig_busy_o  out  1  scan in progress.
- reconfig_count_o  out  8  number of completed scans; saturates at 255.

## Operation
**Snapshot register**
- snap[3:0][8:0] holds the fault map as last seen by the block.
- Fault bits are sticky: every cycle, snap <= snap | permanent_faulty_i.
- new_fault = |(permanent_faulty_i & ~snap).
- A falling input bit is ignored.

**Selection rule for class c**
- H = set of ALUs a with ~snap[a][c].
- |H| >= 3: slots = the three lowest-index members of H, ascending; mode TMR.
- |H| = 2: slots = {h0, h1, h0}; mode DMR.
- |H| = 1: all three slots = h0; mode SINGLE.
- |H| = 0: slots = 0; mode NONE; alu_en = 0000.
- Each table entry stores the three 2-bit slot indices, the 2-bit mode and the 4-bit alu_en.

**FSM states: IDLE, SCAN**
- IDLE: if new_fault, latch snap with the new bits, set idx = 0, go to SCAN.
- SCAN: each cycle, write entry[idx] using the selection rule on snap.
  - idx = 8: go to IDLE and increment reconfig_count_o (saturating at 255).
  - new_fault during SCAN: OR the new bits into snap and restart at idx = 0 next cycle. The count increments only once, when the final scan completes.

**Lookup**
- A request is accepted when req_valid_i && req_ready_o.
- req_ready_o = (state == IDLE).
- For req_class_i > 8: rsp_err_o = 1, mode 11, sel = 0, alu_en = 0.

**Reset**
- Every table entry = sel {0,1,2}, mode TMR, alu_en 0111.
- snap = 0, state IDLE, idx = 0, reconfig_count_o = 0.
- rsp_* = 0, reconfig_busy_o = 0, req_ready_o = 1 from the first cycle after reset.

## Timing
**Lookup latency**
- A request accepted at edge t yields rsp_valid_o and rsp_* registered at edge t+1.
- rsp_valid_o is a one-cycle pulse. rsp_sel_o, rsp_mode_o, rsp_alu_en_o and rsp_err_o hold their value until the next response.
- Back-to-back requests are accepted every cycle while in IDLE.

**Fault detection and scan**
- new_fault seen in cycle t: the block enters SCAN at edge t+1.
- A request accepted in cycle t uses the old table.
- reconfig_busy_o = 1 and req_ready_o = 0 from cycle t+1 through t+9.
- entry[k] is written at edge t+2+k, k = 0..8.
- The block is back in IDLE, with ready = 1, in cycle t+10; reconfig_count_o is updated at that same edge.

**Restart during scan**
- A new fault in a SCAN cycle restarts the scan; busy stays high for 9 further cycles.

**Reset mid-scan**
- Reset mid-scan aborts the scan and restores the reset table; no partial entry survives.

**No combinational paths**
- Every output is driven from a register; there is no combinational input-to-output path.
- Exception: req_ready_o is decoded from the state register only.

## Test plan
- **Reset defaults:** after reset, request class 5 -> next cycle rsp_sel = {0,1,2}, mode 00, alu_en 0111, err 0.
- **Single fault and scan timing:**
  - Stimulus: set permanent_faulty_i[1][0] at cycle t.
  - Required: busy and ready=0 for cycles t+1..t+9; reconfig_count = 1 at t+10.
  - Then request class 0 -> sel {0,2,3}, alu_en 1101, TMR; request class 1 -> still {0,1,2}.
- **Degradation ladder on class 8:**
  - Faults on ALUs 0 and 2 -> sel {1,3,1}, mode 01, alu_en 1010.
  - Adding a fault on ALU 3 -> sel {1,1,1}, mode 10.
  - Adding a fault on ALU 1 -> mode 11, alu_en 0000.
- **Restart and sticky faults:**
  - Stimulus: fault at t, second new fault at t+4; deassert the first fault afterwards.
  - Required: busy through t+13; count increments by exactly 1; the first fault stays applied.
- **Handshake under busy:**
  - Hold req_valid_i during a scan -> no rsp_valid_o until IDLE, then exactly one response per accepted cycle.
- **Invalid class and reset mid-scan:**
  - req_class_i = 12 -> err 1, mode 11.
  - Reset at scan cycle 5 -> table back to defaults, count 0, ready 1.
